// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a synchronous FIFO one word at a time and sends each word as an
//   asynchronous UART frame. A frame is one start bit (low), then DATA_W data
//   bits LSB first, then STOP_BITS stop bits (high). Each bit lasts
//   CLKS_PER_BIT clocks.
//
//   Read handshake: the FIFO has registered read data. The word read in FETCH
//   appears on fifo_dout after the FETCH exit edge. It is captured at the LOAD
//   exit edge. fifo_dout is ignored in every other state.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset (aborts any frame in flight)
//   en          transmit enable; only gates the start of new frames
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO registered read data [DATA_W-1:0]
//   fifo_rd     FIFO read strobe; one cycle per frame
//   tx          serial line, idle high
//   busy        high whenever the FSM is not idle
//   frame_done  one-cycle pulse on the cycle after the last stop clock
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  // Index of the bit that becomes shift[0] after the next shift. The
  // expression collapses to 0 for a one-bit word.
  localparam int SH1 = (DATA_W > 1) ? 1 : 0;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shift;
  logic                bit_end;
  logic                go;

  assign bit_end = (baud_cnt == BAUD_LAST);
  // A new frame may start only when enabled and a word is known to be there.
  assign go      = en & ~fifo_empty;

  // The outputs are registered. Each one is loaded on the edge that enters
  // the state it belongs to, so it always matches the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state   <= FETCH;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          // The word requested in FETCH is now valid on fifo_dout.
          shift    <= fifo_dout;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shift[SH1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt    <= '0;
              frame_done <= 1'b1;
              // Chain straight into the next word with no idle cycle.
              if (go) begin
                state   <= FETCH;
                fifo_rd <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
